irq_ctrl: RTL and testbench

- Interrupt controller directly upstream of the special-register block; drives its single irq_in line.
- Collects up to N_SRC peripheral interrupt sources, synchronises and latches them, applies mask/edge configuration, and selects the winner by fixed priority (lowest index wins).
- Raises one request to the core, gated by the core's interrupt-enable flag.
- Records the serviced source ID so the handler can read it over the special-register bus.

---
 rtl/irq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller feeding the special-register block's irq_in.
// Sources are synchronised, latched as level or edge pending bits, masked, and the
// lowest-index candidate is reported as cur_id when the core acknowledges.
module irq_ctrl #(
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             irq_en_in,
    input  logic             irq_ack,
    output logic             irq_out,
    input  logic             cfg_we,
    input  logic [15:0]      cfg_sel,
    input  logic [15:0]      cfg_in,
    output logic [15:0]      cfg_out
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } state_e;

    localparam logic [15:0] SelMask   = 16'd0;
    localparam logic [15:0] SelEdge   = 16'd1;
    localparam logic [15:0] SelPend   = 16'd2;
    localparam logic [15:0] SelCurId  = 16'd3;
    localparam logic [15:0] SelSwTrig = 16'd4;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] sync_dly_q;
    logic [N_SRC-1:0] sync_lvl;
    logic [N_SRC-1:0] rise;

    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] edge_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;

    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] sw_set;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] cand;
    logic             cand_any;
    logic [3:0]       win;
    logic             ack_take;

    state_e           state_q;
    logic             irq_out_q;
    logic             cur_valid_q;
    logic [3:0]       cur_idx_q;

    // Upper write-data bits are intentionally ignored when N_SRC < 16.
    logic             unused_cfg_in;
    assign unused_cfg_in = ^cfg_in;

    // Synchroniser chain plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            sync_dly_q <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~sync_dly_q;

    assign cand     = pending_q & mask_q;
    assign cand_any = |cand;
    assign ack_take = (state_q == StReq) && irq_ack;

    // Software clear/trigger only ever touch edge-mode bits.
    assign w1c    = (cfg_we && cfg_sel == SelPend)   ? (cfg_in[N_SRC-1:0] & edge_q) : '0;
    assign sw_set = (cfg_we && cfg_sel == SelSwTrig) ? (cfg_in[N_SRC-1:0] & edge_q) : '0;

    // Lowest set candidate bit wins; scan downward so the lowest index is written last.
    always_comb begin
        win = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win = 4'(i);
            end
        end
    end

    // One-hot clear of the acknowledged source.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            ack_clr[i] = ack_take && cand_any && (win == 4'(i));
        end
    end

    // Pending next state: level bits track the input, edge bits latch with set beating clear.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (edge_q[i]) begin
                pending_d[i] = rise[i] | sw_set[i] | (pending_q[i] & ~(w1c[i] | ack_clr[i]));
            end else begin
                pending_d[i] = sync_lvl[i];
            end
        end
    end

    // Configuration and pending registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q    <= '0;
            edge_q    <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (cfg_we && cfg_sel == SelMask) begin
                mask_q <= cfg_in[N_SRC-1:0];
            end
            if (cfg_we && cfg_sel == SelEdge) begin
                edge_q <= cfg_in[N_SRC-1:0];
            end
        end
    end

    // Request handshake FSM with registered irq_out and serviced-source record.
    // Once raised, irq_out stays high until ack so the core never sees a spurious fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            irq_out_q   <= 1'b0;
            cur_valid_q <= 1'b0;
            cur_idx_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (irq_en_in && cand_any) begin
                        state_q   <= StReq;
                        irq_out_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (irq_ack) begin
                        cur_valid_q <= cand_any;
                        cur_idx_q   <= cand_any ? win : 4'd0;
                        state_q     <= StDrop;
                        irq_out_q   <= 1'b0;
                    end
                end
                StDrop: begin
                    // The core clears irq_en after seeing the fall; re-arm only after that.
                    if (!irq_en_in) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    irq_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_out = irq_out_q;

    // Register read mux; unmapped selects and bits above N_SRC read as zero.
    always_comb begin
        cfg_out = '0;
        case (cfg_sel)
            SelMask:  cfg_out[N_SRC-1:0] = mask_q;
            SelEdge:  cfg_out[N_SRC-1:0] = edge_q;
            SelPend:  cfg_out[N_SRC-1:0] = pending_q;
            SelCurId: cfg_out = {cur_valid_q, 11'b0, cur_idx_q};
            default:  cfg_out = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus pushes expected values into a scoreboard queue,
// a monitor on the falling edge pops and compares against irq_out / cfg_out.
module tb_irq_ctrl;

    localparam int N = 8;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic          irq_en_in = 1'b0;
    logic          irq_ack = 1'b0;
    logic          irq_out;
    logic          cfg_we = 1'b0;
    logic [15:0]   cfg_sel = '0;
    logic [15:0]   cfg_in = '0;
    logic [15:0]   cfg_out;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: kind 0 = irq_out, kind 1 = cfg_out at the currently driven cfg_sel.
    int          kind_q [$];
    logic [15:0] exp_q  [$];
    string       name_q [$];

    irq_ctrl #(
        .N_SRC       (N),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .irq_en_in (irq_en_in),
        .irq_ack   (irq_ack),
        .irq_out   (irq_out),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_in    (cfg_in),
        .cfg_out   (cfg_out)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        while (kind_q.size() > 0) begin
            int          k;
            logic [15:0] e;
            logic [15:0] g;
            string       nm;
            k  = kind_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = (k == 0) ? {15'b0, irq_out} : cfg_out;
            n_total++;
            if (g === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, g, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input logic e, input string nm);
        kind_q.push_back(0);
        exp_q.push_back({15'b0, e});
        name_q.push_back(nm);
    endtask

    task automatic expect_rd(input logic [15:0] sel, input logic [15:0] e, input string nm);
        cfg_sel = sel;
        kind_q.push_back(1);
        exp_q.push_back(e);
        name_q.push_back(nm);
        step(1);
    endtask

    task automatic cfg_wr(input logic [15:0] sel, input logic [15:0] data);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_in  = data;
        step(1);
        cfg_we  = 1'b0;
        cfg_in  = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b1;
        step(1);

        // Reset state
        expect_out(1'b0, "rst_irq_out");
        expect_rd(16'd0, 16'h0000, "rst_mask");
        expect_rd(16'd1, 16'h0000, "rst_edge");
        expect_rd(16'd2, 16'h0000, "rst_pend");
        expect_rd(16'd3, 16'h0000, "rst_cur_id");
        expect_rd(16'd4, 16'h0000, "rst_swtrig");

        // Reach REQ, then assert reset mid-request
        cfg_wr(16'd0, 16'h0004);
        cfg_wr(16'd1, 16'h0004);
        irq_en_in  = 1'b1;
        irq_src[2] = 1'b1;
        step(1);
        irq_src[2] = 1'b0;
        step(S + 3);
        expect_out(1'b1, "pre_rst_req");
        step(1);
        rst = 1'b0;
        #1;
        expect_out(1'b0, "rst_mid_req_out");
        expect_rd(16'd0, 16'h0000, "rst_mid_mask");
        expect_rd(16'd1, 16'h0000, "rst_mid_edge");
        expect_rd(16'd2, 16'h0000, "rst_mid_pend");
        expect_rd(16'd3, 16'h0000, "rst_mid_cur_id");
        irq_en_in = 1'b0;
        rst = 1'b1;
        step(1);

        // Edge latency: irq_out rises exactly S+2 edges after the source
        cfg_wr(16'd0, 16'h0004);
        cfg_wr(16'd1, 16'h0004);
        irq_en_in  = 1'b1;
        irq_src[2] = 1'b1;
        for (int k = 0; k < S + 2; k++) begin
            expect_out(1'b0, "lat_low");
            step(1);
            irq_src[2] = 1'b0;
        end
        expect_out(1'b1, "lat_high");
        expect_rd(16'd2, 16'h0004, "lat_pend");
        ack();
        expect_out(1'b0, "ack1_drop");
        expect_rd(16'd3, 16'h8002, "ack1_cur_id");
        expect_rd(16'd2, 16'h0000, "ack1_pend");
        irq_en_in = 1'b0;
        step(1);

        // Priority: bits 5 and 1 together, lowest wins
        cfg_wr(16'd0, 16'h0022);
        cfg_wr(16'd1, 16'h0022);
        irq_en_in = 1'b1;
        irq_src   = 8'h22;
        step(1);
        irq_src   = '0;
        step(S + 2);
        expect_out(1'b1, "prio_req");
        expect_rd(16'd2, 16'h0022, "prio_pend_both");
        ack();
        expect_out(1'b0, "prio_drop");
        expect_rd(16'd3, 16'h8001, "prio_cur_id1");
        expect_rd(16'd2, 16'h0020, "prio_pend_left");
        step(2);
        expect_out(1'b0, "drop_hold_en1");
        irq_en_in = 1'b0;
        step(1);
        irq_en_in = 1'b1;
        step(1);
        expect_out(1'b1, "prio_rereq");
        ack();
        expect_rd(16'd3, 16'h8005, "prio_cur_id2");
        expect_rd(16'd2, 16'h0000, "prio_pend_none");
        irq_en_in = 1'b0;
        step(1);

        // Gating by irq_en_in, then mask removal during REQ gives a spurious ack
        irq_src[1] = 1'b1;
        step(1);
        irq_src[1] = 1'b0;
        step(S + 3);
        expect_out(1'b0, "gate_off");
        expect_rd(16'd2, 16'h0002, "gate_pend");
        irq_en_in = 1'b1;
        expect_out(1'b0, "gate_pre");
        step(2);
        expect_out(1'b1, "gate_on");
        cfg_wr(16'd0, 16'h0000);
        expect_out(1'b1, "mask0_hold");
        step(2);
        expect_out(1'b1, "mask0_hold2");
        ack();
        expect_out(1'b0, "spur_drop");
        expect_rd(16'd3, 16'h0000, "spur_cur_id");
        expect_rd(16'd2, 16'h0002, "spur_pend_kept");
        irq_en_in = 1'b0;
        step(1);
        cfg_wr(16'd2, 16'h0002);
        expect_rd(16'd2, 16'h0000, "w1c_edge_clr");

        // Level mode: ack and W1C leave pending set; re-request after DROP->IDLE
        cfg_wr(16'd1, 16'h0000);
        cfg_wr(16'd0, 16'h0001);
        irq_src[0] = 1'b1;
        irq_en_in  = 1'b1;
        step(S + 3);
        expect_out(1'b1, "lvl_req");
        ack();
        expect_rd(16'd3, 16'h8000, "lvl_cur_id");
        expect_rd(16'd2, 16'h0001, "lvl_pend_after_ack");
        cfg_wr(16'd2, 16'h0001);
        expect_rd(16'd2, 16'h0001, "lvl_w1c_ignored");
        expect_out(1'b0, "lvl_drop");
        irq_en_in = 1'b0;
        step(1);
        irq_en_in = 1'b1;
        step(1);
        expect_out(1'b1, "lvl_rereq");
        ack();
        irq_src[0] = 1'b0;
        irq_en_in  = 1'b0;
        step(S + 2);
        expect_rd(16'd2, 16'h0000, "lvl_pend_follows");

        // Collisions on bit 3: set beats W1C, set beats ack clear
        cfg_wr(16'd0, 16'h0008);
        cfg_wr(16'd1, 16'h0008);
        irq_src[3] = 1'b1;
        step(S);
        cfg_wr(16'd2, 16'h0008);
        expect_rd(16'd2, 16'h0008, "col_w1c_vs_rise");
        irq_src[3] = 1'b0;
        step(S + 1);
        irq_en_in = 1'b1;
        step(1);
        expect_out(1'b1, "col_req");
        irq_src[3] = 1'b1;
        step(S);
        ack();
        expect_rd(16'd3, 16'h8003, "col_ack_cur_id");
        expect_rd(16'd2, 16'h0008, "col_ack_vs_rise");
        irq_en_in = 1'b0;
        step(1);
        cfg_wr(16'd2, 16'h0008);
        expect_rd(16'd2, 16'h0000, "col_w1c_plain");
        irq_src[3] = 1'b0;
        step(S + 1);

        // Software trigger and register corner cases
        cfg_wr(16'd0, 16'h0010);
        cfg_wr(16'd1, 16'h0010);
        irq_en_in = 1'b1;
        cfg_wr(16'd4, 16'h0010);
        expect_rd(16'd2, 16'h0010, "sw_pend");
        expect_out(1'b1, "sw_req");
        expect_rd(16'd4, 16'h0000, "sw_reads_zero");
        cfg_wr(16'd4, 16'h0001);
        expect_rd(16'd2, 16'h0010, "sw_level_ignored");
        cfg_wr(16'd3, 16'hFFFF);
        expect_rd(16'd3, 16'h8003, "cur_id_read_only");
        expect_rd(16'd5, 16'h0000, "sel5_reads_zero");
        cfg_wr(16'd0, 16'hFFFF);
        expect_rd(16'd0, 16'h00FF, "mask_upper_zero");

        step(2);
        if (kind_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations never compared, expected 0", kind_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
